// File: rtl/frame_pos_ctrl.sv
// frame_pos_ctrl: once per frame, at the start of vertical blanking, moves the
// player sprite by the requested step. The candidate position is clamped to the
// visible area and then checked against every wall, one wall per cycle. The move
// is committed only if no wall overlaps. Because the position changes only inside
// vblank, the renderer always sees a stable position during active video.
module frame_pos_ctrl #(
    parameter int H_VISIBLE = 640,
    parameter int V_VISIBLE = 480,
    parameter int PLAYER_W  = 40,
    parameter int WALL_NUM  = 10,
    parameter int WALL_W    = 10,
    parameter int START_X   = 300,
    parameter int START_Y   = 220
) (
    input  logic        pixel_clk,
    input  logic        rst_n,
    input  logic [10:0] hcounter,
    input  logic [10:0] vcounter,
    input  logic [5:0]  move_dx,
    input  logic [5:0]  move_dy,
    input  logic        freeze,
    output logic [3:0]  wall_sel,
    input  logic [10:0] wall_x,
    input  logic [10:0] wall_y,
    output logic [10:0] player_x,
    output logic [10:0] player_y,
    output logic        collide,
    output logic        busy,
    output logic        frame_tick
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LATCH  = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam logic signed [11:0] MAX_X = 12'(H_VISIBLE - PLAYER_W);
    localparam logic signed [11:0] MAX_Y = 12'(V_VISIBLE - PLAYER_W);
    localparam logic [3:0]         LAST_WALL = 4'(WALL_NUM - 1);

    state_t r_state;
    state_t w_next;

    logic [5:0]  r_dx;
    logic [5:0]  r_dy;
    logic        r_freeze;
    logic [10:0] r_cand_x;
    logic [10:0] r_cand_y;
    logic        r_hit;
    logic [3:0]  r_wall_sel;
    logic [10:0] r_player_x;
    logic [10:0] r_player_y;
    logic        r_collide;
    logic        r_frame_tick;

    logic               w_frame_start;
    logic               w_last_wall;
    logic signed [11:0] w_sum_x;
    logic signed [11:0] w_sum_y;
    logic [10:0]        w_cand_x;
    logic [10:0]        w_cand_y;
    logic [11:0]        w_cx;
    logic [11:0]        w_cy;
    logic [11:0]        w_wx;
    logic [11:0]        w_wy;
    logic               w_overlap;

    assign w_frame_start = (vcounter == 11'(V_VISIBLE)) && (hcounter == 11'd0);
    assign w_last_wall   = (r_wall_sel == LAST_WALL);

    // Raw candidate = current position plus sign-extended step, in 12-bit signed
    assign w_sum_x = $signed({1'b0, r_player_x}) + $signed({{6{r_dx[5]}}, r_dx});
    assign w_sum_y = $signed({1'b0, r_player_y}) + $signed({{6{r_dy[5]}}, r_dy});

    // Clamp the candidate so the whole sprite stays inside the visible area
    always_comb begin
        w_cand_x = w_sum_x[10:0];
        w_cand_y = w_sum_y[10:0];
        if (w_sum_x < 12'sd0) begin
            w_cand_x = 11'd0;
        end else if (w_sum_x > MAX_X) begin
            w_cand_x = MAX_X[10:0];
        end
        if (w_sum_y < 12'sd0) begin
            w_cand_y = 11'd0;
        end else if (w_sum_y > MAX_Y) begin
            w_cand_y = MAX_Y[10:0];
        end
    end

    // Square-overlap test against the wall currently addressed by wall_sel;
    // 12-bit operands leave headroom so the right-edge sums never wrap
    assign w_cx = {1'b0, r_cand_x};
    assign w_cy = {1'b0, r_cand_y};
    assign w_wx = {1'b0, wall_x};
    assign w_wy = {1'b0, wall_y};
    assign w_overlap = (w_cx < w_wx + 12'(WALL_W)) && (w_wx < w_cx + 12'(PLAYER_W)) &&
                       (w_cy < w_wy + 12'(WALL_W)) && (w_wy < w_cy + 12'(PLAYER_W));

    // State register
    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a frame start seen outside IDLE is simply ignored
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_frame_start) begin
                    w_next = LATCH;
                end
            end
            LATCH: begin
                w_next = r_freeze ? COMMIT : CHECK;
            end
            CHECK: begin
                if (w_last_wall) begin
                    w_next = COMMIT;
                end
            end
            COMMIT: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Datapath: latch the request, build the candidate, walk the walls, commit
    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            r_dx         <= 6'd0;
            r_dy         <= 6'd0;
            r_freeze     <= 1'b0;
            r_cand_x     <= 11'(START_X);
            r_cand_y     <= 11'(START_Y);
            r_hit        <= 1'b0;
            r_wall_sel   <= 4'd0;
            r_player_x   <= 11'(START_X);
            r_player_y   <= 11'(START_Y);
            r_collide    <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_frame_start) begin
                        r_dx     <= move_dx;
                        r_dy     <= move_dy;
                        r_freeze <= freeze;
                    end
                end
                LATCH: begin
                    r_cand_x   <= w_cand_x;
                    r_cand_y   <= w_cand_y;
                    r_hit      <= r_freeze;
                    r_wall_sel <= 4'd0;
                end
                CHECK: begin
                    r_hit      <= r_hit | w_overlap;
                    r_wall_sel <= w_last_wall ? 4'd0 : r_wall_sel + 4'd1;
                end
                COMMIT: begin
                    if (!r_hit) begin
                        r_player_x <= r_cand_x;
                        r_player_y <= r_cand_y;
                    end
                    r_collide    <= r_hit & ~r_freeze;
                    r_frame_tick <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign wall_sel   = r_wall_sel;
    assign player_x   = r_player_x;
    assign player_y   = r_player_y;
    assign collide    = r_collide;
    assign busy       = (r_state != IDLE);
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_frame_pos_ctrl.sv
// tb_frame_pos_ctrl: directed and randomized frames for frame_pos_ctrl, with a
// behavioural model of one frame's move (clamp, wall scan, commit decision).
module tb_frame_pos_ctrl;

    localparam int WALL_NUM = 10;
    localparam int WALL_W   = 10;
    localparam int PLAYER_W = 40;
    localparam int START_X  = 300;
    localparam int START_Y  = 220;
    localparam int MAX_X    = 640 - PLAYER_W;
    localparam int MAX_Y    = 480 - PLAYER_W;

    logic        pixel_clk = 1'b0;
    logic        rst_n;
    logic [10:0] hcounter;
    logic [10:0] vcounter;
    logic [5:0]  move_dx;
    logic [5:0]  move_dy;
    logic        freeze;
    logic [3:0]  wall_sel;
    logic [10:0] wall_x;
    logic [10:0] wall_y;
    logic [10:0] player_x;
    logic [10:0] player_y;
    logic        collide;
    logic        busy;
    logic        frame_tick;

    int wallX [16];
    int wallY [16];
    int refX;
    int refY;
    int refCollide;
    int assertCount = 0;
    int failCount   = 0;

    frame_pos_ctrl dut (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .hcounter  (hcounter),
        .vcounter  (vcounter),
        .move_dx   (move_dx),
        .move_dy   (move_dy),
        .freeze    (freeze),
        .wall_sel  (wall_sel),
        .wall_x    (wall_x),
        .wall_y    (wall_y),
        .player_x  (player_x),
        .player_y  (player_y),
        .collide   (collide),
        .busy      (busy),
        .frame_tick(frame_tick)
    );

    // 25 MHz pixel clock
    always #20 pixel_clk = ~pixel_clk;

    // Wall table lookup, combinational from wall_sel
    assign wall_x = 11'(wallX[wall_sel]);
    assign wall_y = 11'(wallY[wall_sel]);

    task automatic checkOutput(input string tag, input int observed, input int expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // One frame of the game rule: clamp the step, test every wall, decide
    task automatic modelFrame(input int dx, input int dy, input bit frz);
        int cx;
        int cy;
        bit hit;
        cx = refX + dx;
        cy = refY + dy;
        cx = (cx < 0) ? 0 : ((cx > MAX_X) ? MAX_X : cx);
        cy = (cy < 0) ? 0 : ((cy > MAX_Y) ? MAX_Y : cy);
        hit = 1'b0;
        for (int i = 0; i < WALL_NUM; i++) begin
            if (cx < wallX[i] + WALL_W && wallX[i] < cx + PLAYER_W &&
                cy < wallY[i] + WALL_W && wallY[i] < cy + PLAYER_W) begin
                hit = 1'b1;
            end
        end
        if (frz) begin
            refCollide = 0;
        end else if (hit) begin
            refCollide = 1;
        end else begin
            refCollide = 0;
            refX = cx;
            refY = cy;
        end
    endtask

    function automatic int clampStep(input int v);
        return (v > 31) ? 31 : ((v < -32) ? -32 : v);
    endfunction

    // Run one frame: frame start, scrambled inputs afterwards, timing checks
    task automatic applyStimulus(input int dx, input int dy, input bit frz, input bit pokeBusy);
        int busyLen;
        int tickAt;
        int ticks;
        int busyCycles;
        int oldX;
        int oldY;
        int tickX;
        int tickY;
        int tickCol;
        oldX = refX;
        oldY = refY;
        busyLen = frz ? 2 : WALL_NUM + 2;
        tickAt = -1;
        ticks = 0;
        busyCycles = 0;
        tickX = -1;
        tickY = -1;
        tickCol = -1;
        @(negedge pixel_clk);
        vcounter = 11'd480;
        hcounter = 11'd0;
        move_dx  = 6'(dx);
        move_dy  = 6'(dy);
        freeze   = frz;
        modelFrame(dx, dy, frz);
        for (int k = 1; k <= WALL_NUM + 4; k++) begin
            @(negedge pixel_clk);
            if (k == 1) begin
                vcounter = 11'd0;
                hcounter = 11'd100;
                move_dx  = 6'($urandom);
                move_dy  = 6'($urandom);
                freeze   = 1'($urandom);
            end
            if (pokeBusy && !frz && k == 5) begin
                vcounter = 11'd480;
                hcounter = 11'd0;
            end
            if (k == 6) begin
                vcounter = 11'd0;
                hcounter = 11'd100;
            end
            if (busy) busyCycles++;
            if (frame_tick) begin
                ticks++;
                if (tickAt < 0) begin
                    tickAt  = k;
                    tickX   = int'(player_x);
                    tickY   = int'(player_y);
                    tickCol = int'(collide);
                end
            end
            if (k == busyLen) begin
                checkOutput("hold_x_until_commit", int'(player_x), oldX);
                checkOutput("hold_y_until_commit", int'(player_y), oldY);
            end
            if (frz) checkOutput("freeze_wall_sel", int'(wall_sel), 0);
        end
        checkOutput("tick_cycle", tickAt, busyLen + 1);
        checkOutput("tick_count", ticks, 1);
        checkOutput("busy_cycles", busyCycles, busyLen);
        checkOutput("tick_player_x", tickX, refX);
        checkOutput("tick_player_y", tickY, refY);
        checkOutput("tick_collide", tickCol, refCollide);
    endtask

    task automatic doReset();
        @(negedge pixel_clk);
        rst_n    = 1'b0;
        vcounter = 11'd0;
        hcounter = 11'd100;
        @(negedge pixel_clk);
        rst_n      = 1'b1;
        refX       = START_X;
        refY       = START_Y;
        refCollide = 0;
    endtask

    // Directed scenarios followed by randomized frames
    initial begin
        bit found;
        rst_n    = 1'b0;
        hcounter = 11'd100;
        vcounter = 11'd0;
        move_dx  = 6'd0;
        move_dy  = 6'd0;
        freeze   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wallX[i] = 0;
            wallY[i] = 0;
        end
        refX = START_X;
        refY = START_Y;
        refCollide = 0;

        repeat (2) @(negedge pixel_clk);
        checkOutput("reset_player_x", int'(player_x), 300);
        checkOutput("reset_player_y", int'(player_y), 220);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_tick", int'(frame_tick), 0);
        checkOutput("reset_collide", int'(collide), 0);
        checkOutput("reset_wall_sel", int'(wall_sel), 0);
        rst_n = 1'b1;

        $display("[TB] basic move");
        applyStimulus(5, -3, 1'b0, 1'b1);
        checkOutput("basic_x", int'(player_x), 305);
        checkOutput("basic_y", int'(player_y), 217);
        checkOutput("basic_collide", int'(collide), 0);

        $display("[TB] walk to (598,2) then clamp");
        for (int f = 0; f < 20 && !(refX == 598 && refY == 2); f++) begin
            applyStimulus(clampStep(598 - refX), clampStep(2 - refY), 1'b0, 1'b0);
        end
        checkOutput("walk_x", int'(player_x), 598);
        checkOutput("walk_y", int'(player_y), 2);
        applyStimulus(31, -32, 1'b0, 1'b0);
        checkOutput("clamp_x", int'(player_x), 600);
        checkOutput("clamp_y", int'(player_y), 0);
        checkOutput("clamp_collide", int'(collide), 0);

        $display("[TB] blocked by wall 7");
        doReset();
        wallX[7] = 350;
        wallY[7] = 230;
        applyStimulus(15, 0, 1'b0, 1'b0);
        checkOutput("blocked_x", int'(player_x), 300);
        checkOutput("blocked_y", int'(player_y), 220);
        checkOutput("blocked_collide", int'(collide), 1);
        applyStimulus(-10, 0, 1'b0, 1'b0);
        checkOutput("retreat_x", int'(player_x), 290);
        checkOutput("retreat_collide", int'(collide), 0);

        $display("[TB] edge contact");
        doReset();
        wallX[7] = 340;
        wallY[7] = 220;
        applyStimulus(0, 0, 1'b0, 1'b0);
        checkOutput("touch_collide", int'(collide), 0);
        applyStimulus(1, 0, 1'b0, 1'b0);
        checkOutput("overlap_collide", int'(collide), 1);
        checkOutput("overlap_x", int'(player_x), 300);

        $display("[TB] freeze frame");
        applyStimulus(10, 0, 1'b1, 1'b0);
        checkOutput("freeze_x", int'(player_x), 300);
        checkOutput("freeze_collide", int'(collide), 0);

        $display("[TB] reset during wall scan");
        wallX[7] = 0;
        wallY[7] = 0;
        applyStimulus(7, 0, 1'b0, 1'b0);
        checkOutput("premove_x", int'(player_x), 307);
        @(negedge pixel_clk);
        vcounter = 11'd480;
        hcounter = 11'd0;
        move_dx  = 6'd5;
        move_dy  = 6'd5;
        freeze   = 1'b0;
        found = 1'b0;
        for (int k = 1; k <= WALL_NUM + 4 && !found; k++) begin
            @(negedge pixel_clk);
            vcounter = 11'd0;
            hcounter = 11'd100;
            if (busy && wall_sel == 4'd4) found = 1'b1;
        end
        checkOutput("reached_wall4", int'(found), 1);
        rst_n = 1'b0;
        @(negedge pixel_clk);
        rst_n = 1'b1;
        checkOutput("midreset_busy", int'(busy), 0);
        checkOutput("midreset_x", int'(player_x), 300);
        checkOutput("midreset_y", int'(player_y), 220);
        checkOutput("midreset_tick", int'(frame_tick), 0);
        checkOutput("midreset_wall_sel", int'(wall_sel), 0);
        repeat (WALL_NUM + 2) begin
            @(negedge pixel_clk);
            checkOutput("midreset_no_tick", int'(frame_tick), 0);
        end
        refX = START_X;
        refY = START_Y;
        refCollide = 0;
        applyStimulus(-4, 6, 1'b0, 1'b0);
        checkOutput("after_reset_x", int'(player_x), 296);
        checkOutput("after_reset_y", int'(player_y), 226);

        $display("[TB] randomized frames");
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < 16; i++) begin
                wallX[i] = int'($urandom_range(0, 650));
                wallY[i] = int'($urandom_range(0, 490));
            end
            applyStimulus(int'($urandom_range(0, 63)) - 32, int'($urandom_range(0, 63)) - 32,
                          ($urandom_range(0, 7) == 0), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
